// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the clock divider bank and its channels.
package clkdiv_pkg;

  localparam int CNT_W_DEF    = 32;
  localparam int DIV_RST_DEF  = 2;
  localparam int CHANNELS_DEF = 4;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHAN_W_DEF = chan_idx_w(CHANNELS_DEF);

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic                 en;
  } chan_cfg_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active/pending configuration and
// rising-edge tick. Updates take effect only on a phase boundary or while idle.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_en,
  input  logic             restart,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic             active_en_q, active_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_en_q, pend_en_d;
  logic             pend_q, pend_d;

  logic             running;
  logic             at_bound;
  logic             stop_low;
  logic             apply;
  logic [CNT_W-1:0] apply_div;
  logic             apply_en;

  // A disabled channel keeps counting until its high phase is finished.
  assign running  = active_en_q || clk_q;
  assign at_bound = running && (cnt_q == active_div_q - CNT_W'(1));
  assign stop_low = pend_q && !pend_en_q && !clk_q;

  always_comb begin
    active_div_d = active_div_q;
    active_en_d  = active_en_q;
    cnt_d        = cnt_q;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    pend_div_d   = pend_div_q;
    pend_en_d    = pend_en_q;
    pend_d       = pend_q;
    apply        = 1'b0;
    apply_div    = pend_div_q;
    apply_en     = pend_en_q;

    if (wr) begin
      pend_d     = 1'b1;
      pend_div_d = wr_div;
      pend_en_d  = wr_en;
    end

    if (restart) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (wr) begin
        apply     = 1'b1;
        apply_div = wr_div;
        apply_en  = wr_en;
      end else begin
        apply = pend_q;
      end
    end else if (!running || stop_low) begin
      cnt_d = '0;
      apply = pend_q;
    end else if (at_bound) begin
      cnt_d  = '0;
      clk_d  = !clk_q;
      tick_d = !clk_q;
      apply  = pend_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A zero divisor would never reach a boundary, so it becomes 1.
    if (apply) begin
      active_div_d = (apply_div == '0) ? CNT_W'(1) : apply_div;
      active_en_d  = apply_en;
      pend_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active_div_q <= CNT_W'(DIV_RST);
      active_en_q  <= 1'b0;
      cnt_q        <= '0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      pend_div_q   <= '0;
      pend_en_q    <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      active_div_q <= active_div_d;
      active_en_q  <= active_en_d;
      cnt_q        <= cnt_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      pend_div_q   <= pend_div_d;
      pend_en_q    <= pend_en_d;
      pend_q       <= pend_d;
    end
  end

  assign pend    = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independently programmable clock dividers sharing one input clock,
// with a per-channel config handshake and a common phase-align restart.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int          CHANNELS = CHANNELS_DEF,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_RST  = DIV_RST_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [chan_idx_w(CHANNELS)-1:0]  cfg_chan,
  input  logic [CNT_W-1:0]                 cfg_div,
  input  logic                             cfg_en,
  input  logic                             sync_restart,
  output logic [CHANNELS-1:0]              clk_out,
  output logic [CHANNELS-1:0]              tick
);

  localparam int CHAN_W = chan_idx_w(CHANNELS);

  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] pend;

  // Unmatched indices leave cfg_ready high and select no channel, so the
  // write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr_sel    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) begin
        cfg_ready = !pend[i];
        wr_sel[i] = cfg_valid && !pend[i];
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .wr      (wr_sel[i]),
      .wr_div  (cfg_div),
      .wr_en   (cfg_en),
      .restart (sync_restart),
      .pend    (pend[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: stimulus queues expected tick
// cycles, a negedge monitor matches every observed tick against the queue.
module tb_clock_divider_bank;
  import clkdiv_pkg::*;

  localparam int CH = CHANNELS_DEF;
  localparam int CW = CHAN_W_DEF;

  logic                 clk_in;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_chan;
  logic [CNT_W_DEF-1:0] cfg_div;
  logic                 cfg_en;
  logic                 sync_restart;
  logic [CH-1:0]        clk_out;
  logic [CH-1:0]        tick;

  typedef struct {
    int cyc;
    int chan;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  clock_divider_bank #(
    .CHANNELS (CH),
    .CNT_W    (CNT_W_DEF),
    .DIV_RST  (DIV_RST_DEF)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_div      (cfg_div),
    .cfg_en       (cfg_en),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic chan_cfg_t mkCfg(input int unsigned d, input bit e);
    chan_cfg_t c;
    c.div = d;
    c.en  = e;
    return c;
  endfunction

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  task automatic expectTick(input int chan, input int n);
    exp_t e;
    e.cyc  = n;
    e.chan = chan;
    expQ.push_back(e);
  endtask

  // Offers a write from cycle 'start', waits for cfg_ready, returns the edge
  // number of acceptance; returns at the following negedge.
  task automatic applyStimulus(input int start, input int chan, input chan_cfg_t c, output int acc);
    int tries;
    waitUntil(start);
    cfg_chan  = chan[CW-1:0];
    cfg_div   = c.div;
    cfg_en    = c.en;
    cfg_valid = 1'b1;
    #1;
    tries = 0;
    while (!cfg_ready && tries < 100) begin
      @(negedge clk_in);
      #1;
      tries++;
    end
    if (!cfg_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL cfg_timeout: actual=ready_low required=ready_high chan=%0d", chan);
    end
    @(posedge clk_in);
    #1;
    acc = cyc;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic checkReadyAll(input string name);
    for (int i = 0; i < CH; i++) begin
      cfg_chan = i[CW-1:0];
      #1;
      checkOutput(name, {31'd0, cfg_ready}, 32'd1);
    end
  endtask

  // Called at a negedge: asserts reset mid-cycle and checks the async clear.
  task automatic doReset();
    checkOutput("sb_empty", expQ.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_clk_out", {28'd0, clk_out}, 32'd0);
    checkOutput("rst_tick", {28'd0, tick}, 32'd0);
    checkReadyAll("rst_ready");
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  always @(negedge clk_in) begin : monitor
    int  idx;
    bit  found;
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        if (tick[c]) begin
          found = 1'b0;
          idx   = 0;
          for (int k = 0; k < expQ.size(); k++) begin
            if (!found && expQ[k].cyc == cyc && expQ[k].chan == c) begin
              found = 1'b1;
              idx   = k;
            end
          end
          compared++;
          if (found) begin
            expQ.delete(idx);
          end else begin
            mismatched++;
            $display("[TB] FAIL tick_unexpected: chan=%0d cyc=%0d actual=1 required=0", c, cyc);
          end
          compared++;
          if (clk_out[c] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL tick_skew: chan=%0d cyc=%0d clk_out actual=%0b required=1", c, cyc, clk_out[c]);
          end
        end
      end
      for (int k = expQ.size() - 1; k >= 0; k--) begin
        if (expQ[k].cyc <= cyc) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL tick_missing: chan=%0d cyc=%0d actual=0 required=1", expQ[k].chan, expQ[k].cyc);
          expQ.delete(k);
        end
      end
    end
  end

  initial begin
    int a, w, b, c, d0, d1, r, e, f, g, g1;

    rst_n        = 1'b0;
    cfg_valid    = 1'b0;
    cfg_chan     = '0;
    cfg_div      = '0;
    cfg_en       = 1'b0;
    sync_restart = 1'b0;
    #1;
    checkOutput("init_clk_out", {28'd0, clk_out}, 32'd0);
    checkOutput("init_tick", {28'd0, tick}, 32'd0);
    checkReadyAll("init_ready");
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    checkOutput("idle_after_reset", {28'd0, clk_out}, 32'd0);

    // ch0 div=2 from idle: first rise two edges after apply, period 4
    applyStimulus(cyc, 0, mkCfg(2, 1'b1), a);
    for (int k = 0; k < 4; k++) expectTick(0, a + 3 + 4 * k);
    waitUntil(a + 2); checkOutput("s1_low_before_rise", {28'd0, clk_out}, 32'd0);
    waitUntil(a + 3); checkOutput("s1_rise", {28'd0, clk_out}, 32'd1);
    waitUntil(a + 4); checkOutput("s1_high", {31'd0, clk_out[0]}, 32'd1);
    waitUntil(a + 5); checkOutput("s1_fall", {28'd0, clk_out}, 32'd0);
    waitUntil(a + 16); checkOutput("s1_others_low", {29'd0, clk_out[3:1]}, 32'd0);
    doReset();

    // ch1 div=3, retarget to 5 during the high phase
    applyStimulus(cyc, 1, mkCfg(3, 1'b1), a);
    expectTick(1, a + 4);
    expectTick(1, a + 12);
    expectTick(1, a + 22);
    waitUntil(a + 4); checkOutput("s2_rise", {31'd0, clk_out[1]}, 32'd1);
    applyStimulus(a + 5, 1, mkCfg(5, 1'b1), w);
    checkOutput("s2_accept_edge", w, a + 6);
    cfg_chan = 2'd1; #1; checkOutput("s2_ready_ch1_pend", {31'd0, cfg_ready}, 32'd0);
    cfg_chan = 2'd2; #1; checkOutput("s2_ready_ch2", {31'd0, cfg_ready}, 32'd1);
    checkOutput("s2_still_high", {31'd0, clk_out[1]}, 32'd1);
    waitUntil(a + 7);
    checkOutput("s2_fall_3", {31'd0, clk_out[1]}, 32'd0);
    cfg_chan = 2'd1; #1; checkOutput("s2_ready_ch1_free", {31'd0, cfg_ready}, 32'd1);
    waitUntil(a + 11); checkOutput("s2_low_5a", {31'd0, clk_out[1]}, 32'd0);
    waitUntil(a + 12); checkOutput("s2_rise_5", {31'd0, clk_out[1]}, 32'd1);
    waitUntil(a + 16); checkOutput("s2_high_5", {31'd0, clk_out[1]}, 32'd1);
    waitUntil(a + 17); checkOutput("s2_fall_5", {31'd0, clk_out[1]}, 32'd0);
    waitUntil(a + 23);
    doReset();

    // ch0 div=4 disabled while high: finishes high phase then idles
    applyStimulus(cyc, 0, mkCfg(4, 1'b1), b);
    expectTick(0, b + 5);
    applyStimulus(b + 6, 0, mkCfg(4, 1'b0), w);
    checkOutput("s3_accept_edge", w, b + 7);
    cfg_chan = 2'd0; #1; checkOutput("s3_ready_pend", {31'd0, cfg_ready}, 32'd0);
    waitUntil(b + 8); checkOutput("s3_high_hold", {31'd0, clk_out[0]}, 32'd1);
    waitUntil(b + 9); checkOutput("s3_fall", {31'd0, clk_out[0]}, 32'd0);
    waitUntil(b + 14); checkOutput("s3_idle_a", {31'd0, clk_out[0]}, 32'd0);
    waitUntil(b + 20); checkOutput("s3_idle_b", {31'd0, clk_out[0]}, 32'd0);

    // ch0 re-enabled, then disabled while low: stops without another rise
    applyStimulus(cyc, 0, mkCfg(4, 1'b1), c);
    expectTick(0, c + 5);
    applyStimulus(c + 9, 0, mkCfg(4, 1'b0), w);
    checkOutput("s3b_accept_edge", w, c + 10);
    cfg_chan = 2'd0; #1; checkOutput("s3b_ready_pend", {31'd0, cfg_ready}, 32'd0);
    checkOutput("s3b_low", {31'd0, clk_out[0]}, 32'd0);
    waitUntil(c + 11);
    cfg_chan = 2'd0; #1; checkOutput("s3b_ready_free", {31'd0, cfg_ready}, 32'd1);
    waitUntil(c + 13); checkOutput("s3b_no_rise", {31'd0, clk_out[0]}, 32'd0);
    waitUntil(c + 20); checkOutput("s3b_idle", {31'd0, clk_out[0]}, 32'd0);
    doReset();

    // ch0 div=3 and ch1 div=6, then sync_restart aligns both
    applyStimulus(cyc, 0, mkCfg(3, 1'b1), d0);
    applyStimulus(cyc, 1, mkCfg(6, 1'b1), d1);
    checkOutput("s4_back_to_back", d1, d0 + 1);
    expectTick(0, d0 + 4);
    expectTick(0, d0 + 10);
    expectTick(1, d0 + 8);
    waitUntil(d0 + 12);
    #1;
    sync_restart = 1'b1;
    @(posedge clk_in);
    #1;
    r = cyc;
    @(negedge clk_in);
    sync_restart = 1'b0;
    for (int k = 0; k < 4; k++) expectTick(0, r + 3 + 6 * k);
    expectTick(1, r + 6);
    expectTick(1, r + 18);
    checkOutput("s4_restart_clear", {30'd0, clk_out[1:0]}, 32'd0);
    checkOutput("s4_restart_notick", {28'd0, tick}, 32'd0);
    waitUntil(r + 3); checkOutput("s4_r3", {30'd0, clk_out[1:0]}, 32'd1);
    waitUntil(r + 6); checkOutput("s4_r6", {30'd0, clk_out[1:0]}, 32'd2);
    waitUntil(r + 12); checkOutput("s4_r12", {30'd0, clk_out[1:0]}, 32'd0);
    waitUntil(r + 22);
    doReset();

    // div=0 on ch2 clamps to 1; second write stalls on the pending one
    applyStimulus(cyc, 2, mkCfg(0, 1'b0), e);
    applyStimulus(cyc, 2, mkCfg(0, 1'b1), f);
    checkOutput("s5_stall", f, e + 2);
    for (int k = 0; k < 4; k++) expectTick(2, f + 2 + 2 * k);
    waitUntil(f + 2); checkOutput("s5_rise", {31'd0, clk_out[2]}, 32'd1);
    waitUntil(f + 3); checkOutput("s5_fall", {31'd0, clk_out[2]}, 32'd0);
    waitUntil(f + 9);
    doReset();

    // mid-period asynchronous reset, then channels stay idle
    applyStimulus(cyc, 0, mkCfg(3, 1'b1), g);
    applyStimulus(cyc, 1, mkCfg(5, 1'b1), g1);
    expectTick(0, g + 4);
    expectTick(1, g1 + 6);
    waitUntil(g + 8);
    checkOutput("s6_pre_reset", {28'd0, clk_out}, 32'd2);
    doReset();
    repeat (20) @(negedge clk_in);
    checkOutput("s6_idle", {28'd0, clk_out}, 32'd0);
    checkOutput("final_sb_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel, runtime-programmable clock divider that generates several independent divided clocks and matching rising-edge tick strobes from one input clock. It is the parametrised successor to the fixed single-output divider. Downstream blocks (display refresh, debouncers, UART baud, game timers) draw their rates from it without re-synthesis. Divisor changes are glitch-free: a new value is applied only on a phase boundary.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 32: width of the divisor and of each channel counter.
- `DIV_RST`, 2: divisor loaded into every channel at reset.
- `clk_in` input 1: the only clock; every register is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: a configuration write is offered.
- `cfg_ready` output 1: the addressed channel can accept a write.
- `cfg_chan` input max(1,$clog2(CHANNELS)): target channel index.
- `cfg_div` input CNT_W: new half-period, in clk_in cycles.
- `cfg_en` input 1: new enable state for the target channel.
- `sync_restart` input 1: single-cycle pulse that phase-aligns all channels.
- `clk_out` output CHANNELS: the divided clocks, one bit per channel.
- `tick` output CHANNELS: one-cycle strobe, asserted in the same cycle the matching `clk_out` bit goes high.

## Operation
- Each channel holds these registers: `active_div`, `active_en`, `cnt`, `clk_out` bit, `tick` bit, pending `{div, en}` and a `pend` flag.
- Divide rule: `clk_out` toggles after `active_div` cycles, so the period is 2·`active_div`. DIV_RST=2 gives a /4 output. A divisor of 0 is clamped to 1 when it is applied.
- Running channel:
  - `cnt` increments each cycle.
  - When `cnt == active_div-1`, `cnt` returns to 0 and `clk_out` toggles. This cycle is the boundary.
  - On a 0→1 toggle, `tick` is 1 for exactly that registered cycle.
- Config handshake:
  - A write is accepted when `cfg_valid && cfg_ready`.
  - `cfg_ready = !pend[cfg_chan]`; it is combinational.
  - An accepted write loads the pending registers and sets `pend`.
  - An out-of-range `cfg_chan` gives `cfg_ready=1` and the write is discarded.
- Applying a pending update:
  - Enabled channel: applied at the next boundary, where it copies the pending values into the active ones and clears `pend`. The toggle at that boundary still occurs.
  - Disabled channel: applied on the cycle after acceptance.
- Disable, glitch-free:
  - If `clk_out`=1, the channel finishes its high phase. At that boundary `clk_out` falls, `cnt` is set to 0, and the channel idles low.
  - If `clk_out`=0, the channel stops on the cycle after the update is applied.
- Enable from idle: `cnt` starts at 0 with `clk_out`=0. The first rise and `tick` occur `active_div` cycles after enable takes effect.
- `sync_restart`:
  - All pending updates are applied immediately, including a write accepted in the same cycle.
  - Every `cnt` and `clk_out` bit clears.
  - All enabled channels restart in phase. No `tick` is issued in the restart cycle.
- Reset values:
  - `clk_out`=0, `tick`=0, `cnt`=0, `pend`=0.
  - `active_div`=DIV_RST, `active_en`=0, so all channels are disabled.
  - `cfg_ready`=1.
- A reset asserted mid-period forces the reset values asynchronously. The first edge after deassertion behaves as idle.

## Timing
- Config accepted at cycle t: `pend`=1 from t+1.
  - Disabled channel: applied at t+1, with `pend`=0 again at t+2.
  - Enabled channel: applied at the first boundary at or after t+1.
- `tick[i]` and the rising `clk_out[i]` are both registered and change on the same edge, so their skew is zero.
- If `sync_restart` and a boundary coincide, restart wins: no toggle and no `tick` that cycle.
- Counter arithmetic is unsigned CNT_W and never exceeds `active_div-1`. When CNT_W=32 and div=2^32-1, `cnt` must not wrap.
- Back-to-back writes to different channels are accepted every cycle. A second write to a channel with `pend` set stalls until that channel's boundary.

## Structure
- Package `clkdiv_pkg` holds:
  - CNT_W default and DIV_RST default.
  - Channel-index width constant.
  - Typedef `chan_cfg_t` {div, en}.
- Sub-module `clkdiv_channel` contains one channel: counter, active and pending registers, boundary logic and tick.
- The top level instantiates CHANNELS copies and adds cfg decode, `cfg_ready` muxing and the `sync_restart` fan-out.

## Test plan
- Reset → enable ch0 with div=2: first rise at cycle 2 after apply, then period 4. `tick[0]` pulses every 4 cycles and the other channels stay low.
- ch1 running div=3, write div=5 mid-high-phase → the current phase completes at 3 cycles, then the next phases last 5. `cfg_ready` is low for ch1 until the boundary and high for ch2 throughout.
- ch0 div=4 with `clk_out`=1, write en=0 → high phase completes, then `clk_out` is held 0 with no further ticks. Repeat with `clk_out`=0 → stops on the cycle after apply.
- ch0 div=3 and ch1 div=6 running, `sync_restart` pulse → both outputs are 0 next cycle. Rises follow at +3 and +6 with coincident edges thereafter every 12 cycles.
- Write div=0 to ch2, then enable → it toggles every cycle (period 2) and `tick` fires every 2nd cycle.
- Assert `rst_n`=0 mid-period on all channels → all outputs are 0 immediately and every `cfg_ready` is 1. After release, channels idle until reconfigured.
